// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the shared
// single-port SRAM. The arbiter uses the slave modport; requesters and SRAM use master.
interface mem_port_arbiter_if #(
    parameter int AW = 11,
    parameter int DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_valid;
    logic [DW-1:0] i_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_valid;
    logic [DW-1:0] d_rdata;

    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;
    logic [DW-1:0] m_dout;
    logic          m_oen;
    logic          m_wen;

    logic          stall_if;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_dout,
        output i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
               m_addr, m_din, m_oen, m_wen, stall_if
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_dout,
        input  i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
               m_addr, m_din, m_oen, m_wen, stall_if
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / data) arbiter onto one single-port SRAM, one-cycle read latency.
// Define ARB_FAIRNESS_EN to bound consecutive data grants while a fetch waits.
module mem_port_arbiter #(
    parameter int AW         = 11,
    parameter int DW         = 32,
    parameter int STREAK_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_I    = 2'b01;
    localparam logic [1:0] OWN_D    = 2'b10;

    logic [1:0] r_owner;
    logic       r_d_wr;
    logic       w_i_gnt;
    logic       w_d_gnt;
    logic       w_fair_i;
    logic       w_i_valid;
    logic       w_d_valid;

`ifdef ARB_FAIRNESS_EN
    localparam int SW = (STREAK_MAX < 1) ? 1 : $clog2(STREAK_MAX + 1);
    localparam logic [SW-1:0] STREAK_TOP = SW'(STREAK_MAX);

    logic [SW-1:0] r_streak;

    assign w_fair_i = (r_streak == STREAK_TOP);

    // Streak of data grants taken while a fetch was waiting; saturates at the limit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_streak <= {SW{1'b0}};
        end else if (w_i_gnt || !bus.i_req) begin
            r_streak <= {SW{1'b0}};
        end else if (w_d_gnt && (r_streak != STREAK_TOP)) begin
            r_streak <= r_streak + {{(SW-1){1'b0}}, 1'b1};
        end else begin
            r_streak <= r_streak;
        end
    end
`else
    assign w_fair_i = 1'b0;
`endif

    // Same-cycle grant decision: data wins unless the fetch has waited out its streak
    always_comb begin
        w_i_gnt = 1'b0;
        w_d_gnt = 1'b0;
        if (rst) begin
            w_i_gnt = 1'b0;
            w_d_gnt = 1'b0;
        end else if (bus.d_req && !(bus.i_req && w_fair_i)) begin
            w_d_gnt = 1'b1;
        end else if (bus.i_req) begin
            w_i_gnt = 1'b1;
        end else begin
            w_i_gnt = 1'b0;
            w_d_gnt = 1'b0;
        end
    end

    // SRAM command follows the winning grant; idle bus is parked at zero
    always_comb begin
        bus.m_addr = {AW{1'b0}};
        bus.m_din  = {DW{1'b0}};
        bus.m_oen  = 1'b1;
        bus.m_wen  = 1'b1;
        case ({w_i_gnt, w_d_gnt})
            2'b10: begin
                bus.m_addr = bus.i_addr;
                bus.m_oen  = 1'b0;
            end
            2'b01: begin
                bus.m_addr = bus.d_addr;
                if (bus.d_we) begin
                    bus.m_din = bus.d_wdata;
                    bus.m_wen = 1'b0;
                end else begin
                    bus.m_oen = 1'b0;
                end
            end
            default: begin
                bus.m_addr = {AW{1'b0}};
                bus.m_din  = {DW{1'b0}};
                bus.m_oen  = 1'b1;
                bus.m_wen  = 1'b1;
            end
        endcase
    end

    // Remember who owns next cycle's SRAM response, and whether it was a write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= OWN_NONE;
            r_d_wr  <= 1'b0;
        end else if (w_i_gnt) begin
            r_owner <= OWN_I;
            r_d_wr  <= 1'b0;
        end else if (w_d_gnt) begin
            r_owner <= OWN_D;
            r_d_wr  <= bus.d_we;
        end else begin
            r_owner <= OWN_NONE;
            r_d_wr  <= 1'b0;
        end
    end

    // Reset masks a response already in flight so it is dropped, not delivered late
    always_comb begin
        w_i_valid = 1'b0;
        w_d_valid = 1'b0;
        if (rst) begin
            w_i_valid = 1'b0;
            w_d_valid = 1'b0;
        end else begin
            w_i_valid = (r_owner == OWN_I);
            w_d_valid = (r_owner == OWN_D);
        end
    end

    assign bus.i_gnt    = w_i_gnt;
    assign bus.d_gnt    = w_d_gnt;
    assign bus.i_valid  = w_i_valid;
    assign bus.d_valid  = w_d_valid;
    assign bus.i_rdata  = w_i_valid ? bus.m_dout : {DW{1'b0}};
    assign bus.d_rdata  = (w_d_valid && !r_d_wr) ? bus.m_dout : {DW{1'b0}};
    assign bus.stall_if = bus.i_req && !w_i_gnt && !rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised plus directed bench for mem_port_arbiter against a transaction-level model.
// Honours ARB_FAIRNESS_EN the same way the design does.
module tb_mem_port_arbiter;

    localparam int AW   = 11;
    localparam int DW   = 32;
    localparam int SMAX = 4;
    localparam int MEMN = 1 << AW;
`ifdef ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .STREAK_MAX(SMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] init_word(input int a);
        if (a == 'h010) return 32'hDEAD_BEEF;
        return (32'h9E37_79B9 * 32'(a + 1)) ^ 32'(a);
    endfunction

    // Behavioural SRAM: one-cycle read, writes land at the clock edge
    logic [DW-1:0] sram [0:MEMN-1];
    bit mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int k = 0; k < MEMN; k++) sram[k] <= init_word(k);
            mem_ready <= 1'b1;
        end else begin
            if (!bus.m_wen) sram[bus.m_addr] <= bus.m_din;
            if (!bus.m_oen) bus.m_dout <= sram[bus.m_addr];
        end
    end

    // Reference model: memory image, pending response (0 none, 1 I, 2 D read, 3 D write)
    logic [31:0] ref_mem [0:MEMN-1];
    int          pend = 0;
    logic [31:0] pend_data = 32'h0;
    int          streak = 0;

    task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic r, input logic ir, input logic [AW-1:0] ia,
                         input logic dr, input logic dw, input logic [AW-1:0] da,
                         input logic [DW-1:0] wd, output logic eg_i, output logic eg_d);
        logic ev_i, ev_d, eoen, ewen;
        logic [31:0] er_i, er_d, edin;
        logic [AW-1:0] eaddr;
        @(negedge clk);
        rst = r; bus.i_req = ir; bus.i_addr = ia;
        bus.d_req = dr; bus.d_we = dw; bus.d_addr = da; bus.d_wdata = wd;
        #1;
        ev_i = !r && (pend == 1);
        ev_d = !r && (pend == 2 || pend == 3);
        er_i = ev_i ? pend_data : 32'h0;
        er_d = (ev_d && pend == 2) ? pend_data : 32'h0;
        eg_i = 1'b0;
        eg_d = 1'b0;
        if (!r) begin
            if (dr && ir) begin
                if (FAIR && streak == SMAX) eg_i = 1'b1;
                else eg_d = 1'b1;
            end else if (dr) eg_d = 1'b1;
            else if (ir) eg_i = 1'b1;
        end
        eaddr = eg_i ? ia : (eg_d ? da : {AW{1'b0}});
        eoen  = !(eg_i || (eg_d && !dw));
        ewen  = !(eg_d && dw);
        edin  = (eg_d && dw) ? wd : 32'h0;

        check_value("i_gnt",    64'(bus.i_gnt),    64'(eg_i));
        check_value("d_gnt",    64'(bus.d_gnt),    64'(eg_d));
        check_value("stall_if", 64'(bus.stall_if), 64'(ir && !eg_i && !r));
        check_value("m_addr",   64'(bus.m_addr),   64'(eaddr));
        check_value("m_oen",    64'(bus.m_oen),    64'(eoen));
        check_value("m_wen",    64'(bus.m_wen),    64'(ewen));
        if (!(eg_i || (eg_d && !dw))) check_value("m_din", 64'(bus.m_din), 64'(edin));
        check_value("i_valid",  64'(bus.i_valid),  64'(ev_i));
        check_value("i_rdata",  64'(bus.i_rdata),  64'(er_i));
        check_value("d_valid",  64'(bus.d_valid),  64'(ev_d));
        check_value("d_rdata",  64'(bus.d_rdata),  64'(er_d));

        if (r) begin
            pend = 0; streak = 0;
        end else begin
            if (eg_i) begin
                pend = 1; pend_data = ref_mem[ia];
            end else if (eg_d && dw) begin
                pend = 3; ref_mem[da] = wd;
            end else if (eg_d) begin
                pend = 2; pend_data = ref_mem[da];
            end else begin
                pend = 0;
            end
            if (eg_i || !ir) streak = 0;
            else if (eg_d && streak < SMAX) streak = streak + 1;
        end
    endtask

    initial begin
        logic gi, gd, ir, dr, dw, r;
        logic [AW-1:0] ia, da;
        logic [DW-1:0] wd;
        int ig_cnt;

        for (int k = 0; k < MEMN; k++) ref_mem[k] = init_word(k);
        rst = 1'b1; bus.i_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        bus.i_addr = '0; bus.d_addr = '0; bus.d_wdata = '0;
        @(posedge clk);

        // Reset held with both requests asserted, then release
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 11'h010, 1'b1, 1'b0, 11'h020, 32'h0, gi, gd);
        cycle(1'b0, 1'b0, 11'h0, 1'b0, 1'b0, 11'h0, 32'h0, gi, gd);

        // Fetch read of the DEADBEEF word, then idle to see the response
        cycle(1'b0, 1'b1, 11'h010, 1'b0, 1'b0, 11'h0, 32'h0, gi, gd);
        cycle(1'b0, 1'b0, 11'h0,   1'b0, 1'b0, 11'h0, 32'h0, gi, gd);

        // Contention: data first, fetch next, then both responses in turn
        cycle(1'b0, 1'b1, 11'h030, 1'b1, 1'b0, 11'h020, 32'h0, gi, gd);
        cycle(1'b0, 1'b1, 11'h030, 1'b0, 1'b0, 11'h0,   32'h0, gi, gd);
        cycle(1'b0, 1'b0, 11'h0,   1'b0, 1'b0, 11'h0,   32'h0, gi, gd);

        // Write then immediate read of the top address
        cycle(1'b0, 1'b0, 11'h0, 1'b1, 1'b1, 11'h7FF, 32'h1234_5678, gi, gd);
        cycle(1'b0, 1'b0, 11'h0, 1'b1, 1'b0, 11'h7FF, 32'h0,         gi, gd);
        cycle(1'b0, 1'b0, 11'h0, 1'b0, 1'b0, 11'h0,   32'h0,         gi, gd);

        // Reset lands on the cycle after a fetch grant
        cycle(1'b0, 1'b1, 11'h005, 1'b0, 1'b0, 11'h0, 32'h0, gi, gd);
        cycle(1'b1, 1'b0, 11'h0,   1'b0, 1'b0, 11'h0, 32'h0, gi, gd);
        cycle(1'b0, 1'b0, 11'h0,   1'b0, 1'b0, 11'h0, 32'h0, gi, gd);

        // Both held: fetch is starved unless the fairness limit is built in
        ig_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            cycle(1'b0, 1'b1, 11'h040, 1'b1, 1'b0, AW'(11'h100 + k), 32'h0, gi, gd);
            if (bus.i_gnt === 1'b1) ig_cnt++;
        end
        check_value("fair_i_grants", 64'(ig_cnt), FAIR ? 64'd2 : 64'd0);
        cycle(1'b0, 1'b0, 11'h0, 1'b0, 1'b0, 11'h0, 32'h0, gi, gd);

        // Random traffic over a narrow address window to provoke hazards
        ir = 1'b0; dr = 1'b0; dw = 1'b0; da = '0; wd = '0;
        for (int n = 0; n < 400; n++) begin
            r = ($urandom_range(0, 39) == 0);
            if (!ir && $urandom_range(0, 1) == 1) ir = 1'b1;
            if (!dr && $urandom_range(0, 2) != 0) begin
                dr = 1'b1;
                dw = 1'($urandom_range(0, 1));
                da = AW'($urandom_range(0, 15));
                wd = $urandom;
            end
            ia = AW'($urandom_range(0, 15));
            cycle(r, ir, ia, dr, dw, da, wd, gi, gd);
            if (gi) ir = 1'b0;
            if (gd) dr = 1'b0;
        end
        cycle(1'b0, 1'b0, 11'h0, 1'b0, 1'b0, 11'h0, 32'h0, gi, gd);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 11, memory word-address width.
REQ-002 The block SHALL have parameter DW, default 32, data width.
REQ-003 The block SHALL have parameter STREAK_MAX, default 4, the maximum number of consecutive D grants while I is pending (fairness builds only).
REQ-004 The block SHALL have one clock and one reset: clk input 1, rising-edge clock; rst input 1, synchronous, active-high reset.
REQ-005 i_req  input  1  instruction-fetch read request; held until granted.
REQ-006 i_addr  input  AW  fetch address.
REQ-007 i_gnt  output  1  fetch request accepted this cycle.
REQ-008 i_valid  output  1  i_rdata valid this cycle.
REQ-009 i_rdata  output  DW  fetch read data.
REQ-010 d_req  input  1  data request; held until granted.
REQ-011 d_we  input  1  1 = write, 0 = read.
REQ-012 d_addr  input  AW  data address.
REQ-013 d_wdata  input  DW  write data.
REQ-014 d_gnt  output  1  data request accepted this cycle.
REQ-015 d_valid  output  1  read data valid, or write acknowledge.
REQ-016 d_rdata  output  DW  data read result.
REQ-017 m_addr  output  AW  shared single-port SRAM address.
REQ-018 m_din  output  DW  SRAM write data.
REQ-019 m_dout  input  DW  SRAM read data, one cycle after the read is issued.
REQ-020 m_oen  output  1  SRAM read enable, active-low.
REQ-021 m_wen  output  1  SRAM write enable, active-low.
REQ-022 stall_if  output  1  i_req & ~i_gnt; the fetch stage holds its PC.

Function
REQ-023 Grants SHALL be combinational in the request cycle: at most one of i_gnt or d_gnt SHALL be high per cycle, and neither SHALL be high without its req.
REQ-024 Arbitration rules:
- d_req alone: d_gnt.
- i_req alone: i_gnt.
- Both: d_gnt, unless the fairness override of REQ-033 applies.
REQ-025 Memory drive by grant:
- On i_gnt: m_addr=i_addr, m_oen=0, m_wen=1.
- On d_gnt with d_we=1: m_addr=d_addr, m_din=d_wdata, m_wen=0, m_oen=1.
- On d_gnt with d_we=0: m_addr=d_addr, m_oen=0, m_wen=1.
- No grant: m_oen=1, m_wen=1, m_addr=0, m_din=0.
REQ-026 A registered response owner (NONE/I/D) SHALL record each grant.
- Cycle after an I grant: i_valid=1, i_rdata=m_dout.
- Cycle after a D grant: d_valid=1; d_rdata=m_dout for reads, 0 for writes.
REQ-027 Latency SHALL be exactly one cycle from grant to valid; back-to-back grants SHALL be allowed every cycle with no bubble, including an I/D switch and a write followed by a read.
REQ-028 A read to an address written in the immediately preceding cycle SHALL return the new data (SRAM write-first).
REQ-029 i_rdata and d_rdata SHALL be 0 when their valid is low.
REQ-030 Request inputs that change while not granted SHALL be ignored until grant, with no buffering and no queue.

Reset
REQ-031 While rst=1, the block SHALL drive: i_gnt=d_gnt=0, i_valid=d_valid=0, m_oen=m_wen=1, stall_if=0, owner=NONE, streak counter=0.
REQ-032 Reset asserted with a read in flight SHALL drop that read; no valid SHALL appear in the cycle after reset deasserts.

Configuration
REQ-033 With macro ARB_FAIRNESS_EN defined, a counter SHALL behave as follows:
- Increments on each d_gnt issued while i_req=1.
- Clears on any i_gnt or when i_req=0.
- Saturates at STREAK_MAX.
- When it equals STREAK_MAX and both requests are present, i_gnt is issued instead of d_gnt.
REQ-034 Without ARB_FAIRNESS_EN, the counter SHALL be absent and D SHALL have strict priority; starvation of I is permitted.

Verification
REQ-035 Reset check: rst high 3 cycles with i_req=d_req=1 -> no grants, m_oen=m_wen=1, no valid in the cycle after release.
REQ-036 Fetch read: mem[0x010]=0xDEADBEEF, i_req with i_addr=0x010 -> i_gnt same cycle, i_valid with 0xDEADBEEF next cycle, stall_if=0.
REQ-037 Contention: i_req and d_req (read 0x020) together -> d_gnt, stall_if=1; next cycle i_gnt, d_valid; following cycle i_valid.
REQ-038 Write-then-read: D write 0x7FF=0x12345678, then D read 0x7FF back-to-back -> m_wen=0 then m_oen=0; d_valid ack (d_rdata=0), then d_rdata=0x12345678.
REQ-039 Fairness, ARB_FAIRNESS_EN defined, STREAK_MAX=4: d_req and i_req held high continuously -> grant pattern D,D,D,D,I repeating. Without the macro -> I never granted.
REQ-040 Reset mid-flight: assert rst in the cycle after an I grant -> i_valid stays 0, and the owner returns to NONE.
